// File: rtl/writeback_pkg.sv
// Shared definitions for the LC3 writeback stage.
// Holds the write-back source encoding, condition-code bit positions and
// the data-path / register-address widths used by the register file.
package writeback_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned REG_ADDR_W = 3;

    // Condition-code bit positions within psr.
    localparam int unsigned PSR_N = 2;
    localparam int unsigned PSR_Z = 1;
    localparam int unsigned PSR_P = 0;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2,
        WB_NPC = 2'd3
    } wb_src_t;

endpackage

// File: rtl/writeback_regfile_array.sv
// General-purpose register storage: NumRegs x DataW.
// One synchronous write port, two combinational read ports, synchronous
// active-high reset that clears every entry.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   we_i       write enable
//   waddr_i    write index
//   wdata_i    write data
//   raddr1_i   read port 1 index,  rdata1_o read port 1 data
//   raddr2_i   read port 2 index,  rdata2_o read port 2 data
module writeback_regfile_array #(
    parameter int unsigned DataW   = 16,
    parameter int unsigned NumRegs = 8,
    localparam int unsigned AddrW  = $clog2(NumRegs)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr1_i,
    output logic [DataW-1:0] rdata1_o,
    input  logic [AddrW-1:0] raddr2_i,
    output logic [DataW-1:0] rdata2_o
);

    logic [DataW-1:0] regs_q [NumRegs];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads come straight from storage: no write-to-read bypass.
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/writeback_regfile.sv
// LC3 writeback stage: selects the write-back source, commits it to the
// register file and updates the {N,Z,P} condition code.
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   enable_writeback   commit enable for register write and psr update
//   W_Control          source select: 0 aluout, 1 memout, 2 pcout, 3 npc
//   aluout/memout/pcout/npc  candidate write-back data
//   dr, sr1, sr2       destination and source register indices
//   VSR1, VSR2         R[sr1], R[sr2] (combinational)
//   psr                registered condition code {N,Z,P}
module writeback_regfile #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned AddrW   = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_writeback,
    input  logic [1:0]        W_Control,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] memout,
    input  logic [DATA_W-1:0] pcout,
    input  logic [DATA_W-1:0] npc,
    input  logic [AddrW-1:0]  dr,
    input  logic [AddrW-1:0]  sr1,
    input  logic [AddrW-1:0]  sr2,
    output logic [DATA_W-1:0] VSR1,
    output logic [DATA_W-1:0] VSR2,
    output logic [2:0]        psr
);

    import writeback_pkg::*;

    logic [DATA_W-1:0] wb_data;
    logic [2:0]        psr_d, psr_q;

    always_comb begin
        wb_data = aluout;
        case (wb_src_t'(W_Control))
            WB_ALU: wb_data = aluout;
            WB_MEM: wb_data = memout;
            WB_PC:  wb_data = pcout;
            WB_NPC: wb_data = npc;
            default: wb_data = aluout;
        endcase
    end

    always_comb begin
        psr_d        = psr_q;
        if (enable_writeback) begin
            psr_d[PSR_N] = wb_data[DATA_W-1];
            psr_d[PSR_Z] = (wb_data == '0);
            psr_d[PSR_P] = ~wb_data[DATA_W-1] & (wb_data != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            psr_q <= 3'b000;
        end else begin
            psr_q <= psr_d;
        end
    end

    assign psr = psr_q;

    writeback_regfile_array #(
        .DataW   (DATA_W),
        .NumRegs (NUM_REGS)
    ) u_array (
        .clk_i    (clock),
        .rst_i    (reset),
        .we_i     (enable_writeback),
        .waddr_i  (dr),
        .wdata_i  (wb_data),
        .raddr1_i (sr1),
        .rdata1_o (VSR1),
        .raddr2_i (sr2),
        .rdata2_o (VSR2)
    );

endmodule
